qsfp_sideband_ctrl: RTL and testbench
=====================================

Name: qsfp_sideband_ctrl

Overview:
Per-cage management sideband controller for a QSFP/QSFP-DD module. It sits between the board top pins (MODPRSN, INTN, RESETN, MODSELN, INITMODE) and the management/I2C logic. It synchronises and debounces module presence, sequences module reset and initialisation on insertion or software request, gates module select, and latches module interrupts. The same block is instantiated once for the ZQSFP cage and once for the QSFPDD cage.

Parameters:
DEBOUNCE_CYCLES, 1000, consecutive stable synchronised samples required before presence changes (min 1)
RESET_CYCLES, 1000, clock cycles RESETN is held low in RST (min 1)
INIT_CYCLES, 200000, clock cycles waited after reset release before READY (min 1)

Ports:
FPGA_SYSTEM_CLK  in  1  system clock; all logic on rising edge
FPGA_SYS_RESETN  in  1  asynchronous active-low reset
mod_prsn_i  in  1  raw module-present pin, active low, asynchronous
mod_intn_i  in  1  raw module interrupt pin, active low, asynchronous
sw_reset_req  in  1  single-cycle pulse requesting module reset
lp_mode_req  in  1  level; 1 = low-power mode requested once READY
sel_req  in  1  level; management requests module select for I2C
int_clear  in  1  single-cycle pulse clearing int_pending
qsfp_resetn_o  out  1  to RESETN pin, active low
qsfp_modseln_o  out  1  to MODSELN pin, active low
qsfp_initmode_o  out  1  to INITMODE/LPMode pin, 1 = low power
mod_present  out  1  debounced presence, 1 = present
mod_ready  out  1  1 while in READY
int_pending  out  1  latched module interrupt
state_o  out  2  current state encoding

Behaviour:
- Reset (FPGA_SYS_RESETN=0, async): state ABSENT; qsfp_resetn_o=0, qsfp_modseln_o=1, qsfp_initmode_o=1, mod_present=0, mod_ready=0, int_pending=0, state_o=0. Synchroniser flops reset to 1. Debounce stable value resets to 1 (absent). All counters reset to 0.
- Synchronisers: two-flop synchroniser on each of mod_prsn_i and mod_intn_i; 2-cycle latency.
- Debounce:
  - While the synchronised prsn equals the stable value, the counter is 0.
  - Otherwise the counter increments each cycle. The stable value toggles in the cycle the count would reach DEBOUNCE_CYCLES, and the counter returns to 0.
  - Any bounce back to the stable value before that resets the counter.
  - mod_present = ~stable, registered.
  - Input edge to mod_present change = 2 + DEBOUNCE_CYCLES cycles.
- States: ABSENT=0, RST=1, INIT=2, READY=3. A 32-bit timer is cleared on every state entry.
  - ABSENT: qsfp_resetn_o=0. Go to RST the cycle after mod_present=1.
  - RST: qsfp_resetn_o=0. Go to INIT after RESET_CYCLES cycles in RST.
  - INIT: qsfp_resetn_o=1. Go to READY after INIT_CYCLES cycles in INIT.
  - READY: qsfp_resetn_o=1, mod_ready=1.
- Transition priority, highest first:
  1. mod_present=0 forces ABSENT from any state.
  2. sw_reset_req in RST/INIT/READY goes to RST and restarts the timer, including when already in RST. sw_reset_req in ABSENT is ignored.
  3. Timer expiry.
- Outputs are registered with state:
  - qsfp_initmode_o = 1 in ABSENT/RST/INIT; in READY it equals lp_mode_req, registered (1-cycle latency).
  - qsfp_modseln_o = 0 only when in READY and sel_req=1, registered (1-cycle latency); 1 otherwise.
- Interrupt:
  - int_pending sets the cycle after the synchronised intn=0 while state is READY.
  - int_clear clears int_pending; set wins when int_clear coincides with intn still low.
  - int_pending is forced to 0 in any state other than READY, and cleared on exit from READY.
- Module removal mid-sequence: ABSENT is entered the cycle after mod_present falls. The same cycle, qsfp_resetn_o=0, qsfp_modseln_o=1 and qsfp_initmode_o=1.
- Async reset mid-sequence: all outputs return immediately to their reset values.

Test Plan:
Run with DEBOUNCE_CYCLES=4, RESET_CYCLES=8, INIT_CYCLES=16.
1. Insertion: drive mod_prsn_i 1->0 at cycle 0 and hold -> mod_present=1 at cycle 6; state RST at 7 with qsfp_resetn_o=0; INIT at 15 with qsfp_resetn_o=1; READY and mod_ready=1 at 31.
2. Bounce: pulse mod_prsn_i low for 3 cycles, then high -> mod_present stays 0; state stays ABSENT; qsfp_resetn_o stays 0.
3. Software reset in READY: pulse sw_reset_req -> next cycle state RST, qsfp_resetn_o=0, mod_ready=0; READY again exactly 8+16 cycles later. A second pulse mid-RST restarts the 8-cycle count.
4. Select and low-power mode: in READY, set sel_req=1 and lp_mode_req=0 -> next cycle qsfp_modseln_o=0, qsfp_initmode_o=0. In INIT, sel_req=1 -> qsfp_modseln_o stays 1 and qsfp_initmode_o stays 1.
5. Interrupt: in READY, drive mod_intn_i low for 5 cycles -> int_pending=1 three cycles after the fall. int_clear while intn is still low -> int_pending stays 1. int_clear after intn returns high and has propagated through the synchroniser -> int_pending=0.
6. Removal in INIT: release mod_prsn_i high -> mod_present=0 after 6 cycles; next cycle ABSENT with qsfp_resetn_o=0, qsfp_modseln_o=1, qsfp_initmode_o=1, int_pending=0. Asserting FPGA_SYS_RESETN low mid-INIT immediately restores all reset values.

Source files
------------

// File: rtl/qsfp_sideband_ctrl.sv
// qsfp_sideband_ctrl
// Management sideband controller for one QSFP / QSFP-DD cage. It synchronises
// and debounces the module-present pin, sequences module reset and
// initialisation on insertion or software request, gates module select for
// I2C access and latches module interrupts while the module is ready.
//
// Ports:
//   FPGA_SYSTEM_CLK  system clock, rising edge
//   FPGA_SYS_RESETN  asynchronous active-low reset
//   mod_prsn_i       raw module-present pin (active low, asynchronous)
//   mod_intn_i       raw module interrupt pin (active low, asynchronous)
//   sw_reset_req     one-cycle pulse: restart the module reset sequence
//   lp_mode_req      level: low-power mode wanted once ready
//   sel_req          level: management wants module select for I2C
//   int_clear        one-cycle pulse: clear int_pending
//   qsfp_resetn_o    RESETN pin (active low)
//   qsfp_modseln_o   MODSELN pin (active low)
//   qsfp_initmode_o  INITMODE/LPMode pin (1 = low power)
//   mod_present      debounced presence (1 = present)
//   mod_ready        1 while the sequencer is in READY
//   int_pending      latched module interrupt
//   state_o          sequencer state (0 ABSENT, 1 RST, 2 INIT, 3 READY)
//
// Handshake: there is no valid/ready pairing here. sw_reset_req and
// int_clear are sampled on every rising edge and act once per high cycle;
// lp_mode_req and sel_req are levels sampled every cycle. Every output is a
// register, so each responds one cycle after the edge that sampled its cause.

module qsfp_sideband_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter int unsigned RESET_CYCLES    = 1000,
    parameter int unsigned INIT_CYCLES     = 200000
) (
    input  logic       FPGA_SYSTEM_CLK,
    input  logic       FPGA_SYS_RESETN,
    input  logic       mod_prsn_i,
    input  logic       mod_intn_i,
    input  logic       sw_reset_req,
    input  logic       lp_mode_req,
    input  logic       sel_req,
    input  logic       int_clear,
    output logic       qsfp_resetn_o,
    output logic       qsfp_modseln_o,
    output logic       qsfp_initmode_o,
    output logic       mod_present,
    output logic       mod_ready,
    output logic       int_pending,
    output logic [1:0] state_o
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_ABSENT = 2'd0,
        ST_RST    = 2'd1,
        ST_INIT   = 2'd2,
        ST_READY  = 2'd3
    } state_t;

    logic            prsn_s1, prsn_s2;
    logic            intn_s1, intn_s2;
    logic            db_stable;
    logic [DB_W-1:0] db_cnt;
    state_t          state, state_nxt;
    logic [31:0]     timer;
    logic            sw_restart;

    // Two-flop synchronisers plus presence debounce. Flops idle at 1 so an
    // empty cage reads as "absent, no interrupt" straight out of reset.
    // mod_present is loaded alongside the stable value so the debounced edge
    // appears DEBOUNCE_CYCLES cycles after the synchronised edge.
    always_ff @(posedge FPGA_SYSTEM_CLK or negedge FPGA_SYS_RESETN) begin
        if (!FPGA_SYS_RESETN) begin
            prsn_s1     <= 1'b1;
            prsn_s2     <= 1'b1;
            intn_s1     <= 1'b1;
            intn_s2     <= 1'b1;
            db_stable   <= 1'b1;
            db_cnt      <= '0;
            mod_present <= 1'b0;
        end else begin
            prsn_s1 <= mod_prsn_i;
            prsn_s2 <= prsn_s1;
            intn_s1 <= mod_intn_i;
            intn_s2 <= intn_s1;
            if (prsn_s2 == db_stable) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                db_stable   <= ~db_stable;
                mod_present <= db_stable;
                db_cnt      <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // A software request while already in RST keeps the state but must still
    // restart the reset timer, so it is tracked separately from a state change.
    always_comb begin
        state_nxt  = state;
        sw_restart = mod_present && sw_reset_req && (state != ST_ABSENT);
        if (!mod_present) begin
            state_nxt = ST_ABSENT;
        end else if (sw_restart) begin
            state_nxt = ST_RST;
        end else begin
            case (state)
                ST_ABSENT: state_nxt = ST_RST;
                ST_RST:    if (timer == 32'(RESET_CYCLES - 1)) state_nxt = ST_INIT;
                ST_INIT:   if (timer == 32'(INIT_CYCLES - 1))  state_nxt = ST_READY;
                default:   state_nxt = ST_READY;
            endcase
        end
    end

    // Sequencer with outputs registered from the next state, so pins change
    // in the same cycle the state does.
    always_ff @(posedge FPGA_SYSTEM_CLK or negedge FPGA_SYS_RESETN) begin
        if (!FPGA_SYS_RESETN) begin
            state           <= ST_ABSENT;
            timer           <= '0;
            qsfp_resetn_o   <= 1'b0;
            qsfp_modseln_o  <= 1'b1;
            qsfp_initmode_o <= 1'b1;
            mod_ready       <= 1'b0;
            int_pending     <= 1'b0;
        end else begin
            state <= state_nxt;
            if ((state_nxt != state) || sw_restart) begin
                timer <= '0;
            end else if ((state == ST_RST) || (state == ST_INIT)) begin
                timer <= timer + 32'd1;
            end

            qsfp_resetn_o   <= (state_nxt == ST_INIT) || (state_nxt == ST_READY);
            mod_ready       <= (state_nxt == ST_READY);
            qsfp_initmode_o <= (state_nxt == ST_READY) ? lp_mode_req : 1'b1;
            qsfp_modseln_o  <= ~((state_nxt == ST_READY) && sel_req);

            // Set has priority over clear; leaving READY always drops it.
            if (state_nxt != ST_READY) begin
                int_pending <= 1'b0;
            end else if ((state == ST_READY) && !intn_s2) begin
                int_pending <= 1'b1;
            end else if (int_clear) begin
                int_pending <= 1'b0;
            end
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_qsfp_sideband_ctrl.sv
module tb_qsfp_sideband_ctrl;

    localparam int DB = 4;
    localparam int RC = 8;
    localparam int IC = 16;
    localparam int W  = 8;
    localparam logic [W-1:0] RESET_VEC = 8'b0000_0011;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    logic mod_prsn_i, mod_intn_i, sw_reset_req, lp_mode_req, sel_req, int_clear;
    logic qsfp_resetn_o, qsfp_modseln_o, qsfp_initmode_o;
    logic mod_present, mod_ready, int_pending;
    logic [1:0] state_o;
    logic [W-1:0] dut_vec;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    qsfp_sideband_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .RESET_CYCLES   (RC),
        .INIT_CYCLES    (IC)
    ) dut (
        .FPGA_SYSTEM_CLK(clk),
        .FPGA_SYS_RESETN(rst_n),
        .mod_prsn_i     (mod_prsn_i),
        .mod_intn_i     (mod_intn_i),
        .sw_reset_req   (sw_reset_req),
        .lp_mode_req    (lp_mode_req),
        .sel_req        (sel_req),
        .int_clear      (int_clear),
        .qsfp_resetn_o  (qsfp_resetn_o),
        .qsfp_modseln_o (qsfp_modseln_o),
        .qsfp_initmode_o(qsfp_initmode_o),
        .mod_present    (mod_present),
        .mod_ready      (mod_ready),
        .int_pending    (int_pending),
        .state_o        (state_o)
    );

    // {state, present, ready, int_pending, resetn, modseln, initmode}
    assign dut_vec = {state_o, mod_present, mod_ready, int_pending,
                      qsfp_resetn_o, qsfp_modseln_o, qsfp_initmode_o};

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int checks   = 0;
    int failures = 0;
    int cyc_no   = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            checks++;
            if (dut_vec !== e) begin
                failures++;
                $display("FAIL outputs cycle %0d: got %b expected %b", cyc_no, dut_vec, e);
            end
        end
    end

    // ---------------- reference model ----------------
    // Presence: a synchronised level must disagree with the accepted level
    // for DB consecutive samples to be accepted. Sequencing: each (re)start
    // records the cycle it began; the phase follows from elapsed time alone.
    logic m_s1p, m_s2p, m_s1i, m_s2i, m_stable, m_present, m_active, m_int;
    int   m_run, m_cyc, m_start, m_state;

    function automatic int phase_now();
        int age;
        if (!m_active) return 0;
        age = m_cyc - m_start;
        if (age < RC) return 1;
        if (age < RC + IC) return 2;
        return 3;
    endfunction

    task automatic model_reset();
        m_s1p = 1'b1; m_s2p = 1'b1; m_s1i = 1'b1; m_s2i = 1'b1;
        m_stable = 1'b1; m_present = 1'b0; m_active = 1'b0; m_int = 1'b0;
        m_run = 0; m_start = 0; m_state = 0;
    endtask

    task automatic model_step();
        int prev;
        logic [1:0] st;
        logic rdy, rstn, seln, initm;
        m_cyc++;
        cyc_no = m_cyc;
        if (!rst_n) begin
            model_reset();
            exp_q.push_back(RESET_VEC);
            return;
        end
        prev = m_state;
        if (!m_present) m_active = 1'b0;
        else if (!m_active || sw_reset_req) begin
            m_active = 1'b1;
            m_start  = m_cyc;
        end
        m_state = phase_now();
        if (m_state != 3) m_int = 1'b0;
        else if (prev == 3 && !m_s2i) m_int = 1'b1;
        else if (int_clear) m_int = 1'b0;
        rdy   = (m_state == 3);
        rstn  = (m_state >= 2);
        seln  = !(rdy && sel_req);
        initm = rdy ? lp_mode_req : 1'b1;
        if (m_s2p == m_stable) m_run = 0;
        else begin
            m_run++;
            if (m_run == DB) begin
                m_stable = ~m_stable;
                m_run = 0;
            end
        end
        m_present = ~m_stable;
        m_s2p = m_s1p; m_s1p = mod_prsn_i;
        m_s2i = m_s1i; m_s1i = mod_intn_i;
        st = 2'(m_state);
        exp_q.push_back({st, m_present, rdy, m_int, rstn, seln, initm});
    endtask

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic pulse_sw();
        sw_reset_req = 1'b1;
        tick();
        sw_reset_req = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int k_pres, k_rst, k_init, k_rdy, k_abs, len;
        rst_n = 1'b1;
        mod_prsn_i = 1'b1; mod_intn_i = 1'b1; sw_reset_req = 1'b0;
        lp_mode_req = 1'b1; sel_req = 1'b0; int_clear = 1'b0;
        m_cyc = 0;
        model_reset();
        #2 rst_n = 1'b0;
        #1 check("reset_state", int'(dut_vec), int'(RESET_VEC));
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (5) tick();

        // Short presence glitches must never be accepted.
        for (int r = 0; r < 4; r++) begin
            len = $urandom_range(1, DB - 1);
            mod_prsn_i = 1'b0;
            repeat (len) tick();
            mod_prsn_i = 1'b1;
            repeat (10) tick();
            check("bounce_present", int'(mod_present), 0);
            check("bounce_state", int'(state_o), 0);
            check("bounce_resetn", int'(qsfp_resetn_o), 0);
        end

        // Insertion timeline measured from the pin edge.
        k_pres = -1; k_rst = -1; k_init = -1; k_rdy = -1;
        mod_prsn_i = 1'b0;
        for (int k = 1; k <= 45; k++) begin
            tick();
            if (k_pres < 0 && mod_present) k_pres = k;
            if (k_rst < 0 && state_o == 2'd1) k_rst = k;
            if (k_init < 0 && state_o == 2'd2) k_init = k;
            if (k_rdy < 0 && mod_ready) k_rdy = k;
        end
        check("insert_present_cycle", k_pres, DB + 2);
        check("insert_rst_cycle", k_rst, DB + 3);
        check("insert_init_cycle", k_init, DB + 3 + RC);
        check("insert_ready_cycle", k_rdy, DB + 3 + RC + IC);

        // Select / low-power in READY.
        sel_req = 1'b1; lp_mode_req = 1'b0;
        tick();
        check("ready_modseln", int'(qsfp_modseln_o), 0);
        check("ready_initmode", int'(qsfp_initmode_o), 0);
        for (int k = 0; k < 20; k++) begin
            sel_req = 1'($urandom_range(0, 1));
            lp_mode_req = 1'($urandom_range(0, 1));
            tick();
        end

        // Software reset from READY; select held requested through INIT.
        sel_req = 1'b1; lp_mode_req = 1'b0;
        k_rdy = -1;
        sw_reset_req = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            sw_reset_req = 1'b0;
            if (k == 1) begin
                check("swrst_state", int'(state_o), 1);
                check("swrst_resetn", int'(qsfp_resetn_o), 0);
                check("swrst_ready", int'(mod_ready), 0);
            end
            if (k == 20) begin
                check("init_state", int'(state_o), 2);
                check("init_modseln", int'(qsfp_modseln_o), 1);
                check("init_initmode", int'(qsfp_initmode_o), 1);
            end
            if (k_rdy < 0 && mod_ready) k_rdy = k;
        end
        check("swrst_ready_cycle", k_rdy, 1 + RC + IC);

        // Second request mid-RST restarts the reset count.
        k_rdy = -1;
        pulse_sw();
        tick(); tick();
        pulse_sw();
        for (int k = 5; k <= 40; k++) begin
            tick();
            if (k_rdy < 0 && mod_ready) k_rdy = k;
        end
        check("swrst_restart_ready_cycle", k_rdy, 4 + RC + IC);

        // Interrupt: set latency, set beats clear, then clear once pin is high.
        int_clear = 1'b1;
        tick();
        int_clear = 1'b0;
        k_pres = -1;
        mod_intn_i = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            if (k == 5) int_clear = 1'b1;
            tick();
            int_clear = 1'b0;
            if (k_pres < 0 && int_pending) k_pres = k;
        end
        check("int_set_cycle", k_pres, 3);
        check("int_clear_while_low", int'(int_pending), 1);
        mod_intn_i = 1'b1;
        tick(); tick();
        int_clear = 1'b1;
        tick();
        int_clear = 1'b0;
        check("int_clear_after_high", int'(int_pending), 0);

        // Random activity while present.
        for (int k = 0; k < 300; k++) begin
            sel_req      = 1'($urandom_range(0, 1));
            lp_mode_req  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0) mod_intn_i = ~mod_intn_i;
            int_clear    = ($urandom_range(0, 6) == 0);
            sw_reset_req = ($urandom_range(0, 70) == 0);
            tick();
        end
        int_clear = 1'b0; sw_reset_req = 1'b0; mod_intn_i = 1'b0;

        // Removal in INIT with an interrupt pin held low.
        pulse_sw();
        repeat (12) tick();
        check("removal_pre_state", int'(state_o), 2);
        k_pres = -1; k_abs = -1;
        mod_prsn_i = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k_pres < 0 && !mod_present) k_pres = k;
            if (k_abs < 0 && state_o == 2'd0) begin
                k_abs = k;
                check("removal_modseln", int'(qsfp_modseln_o), 1);
                check("removal_initmode", int'(qsfp_initmode_o), 1);
                check("removal_int", int'(int_pending), 0);
            end
        end
        check("removal_present_cycle", k_pres, DB + 2);
        check("removal_absent_cycle", k_abs, DB + 3);
        mod_intn_i = 1'b1;

        // Async reset mid-INIT.
        mod_prsn_i = 1'b0;
        repeat (DB + 3 + RC + 4) tick();
        check("async_pre_state", int'(state_o), 2);
        rst_n = 1'b0;
        exp_q.delete();
        #1 check("async_reset_outputs", int'(dut_vec), int'(RESET_VEC));
        tick(); tick();
        rst_n = 1'b1;
        repeat (40) tick();

        // Random presence changes with glitches.
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 60) == 0) mod_prsn_i = ~mod_prsn_i;
            if ($urandom_range(0, 8) == 0) mod_intn_i = ~mod_intn_i;
            sel_req      = 1'($urandom_range(0, 1));
            lp_mode_req  = 1'($urandom_range(0, 1));
            int_clear    = ($urandom_range(0, 6) == 0);
            sw_reset_req = ($urandom_range(0, 90) == 0);
            tick();
        end

        @(negedge clk);
        #1 check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
